// File: rtl/mouse_bcd_conv.sv
// mouse_bcd_conv: turns PS/2 X/Y movement into signed 3-digit BCD and holds it for the LCD sequencer
module mouse_bcd_conv #(
    parameter int HOLD = 2000000,
    parameter int HW   = 21
) (
    input  logic       CLK,
    input  logic       RSTN,
    input  logic       dav,
    input  logic [1:0] sign,
    input  logic [1:0] ovf,
    input  logic [7:0] mousexdata,
    input  logic [7:0] mouseydata,
    output logic       dataav,
    output logic       xneg,
    output logic       yneg,
    output logic [3:0] xmsdigit,
    output logic [3:0] xmiddigit,
    output logic [3:0] xlsdigit,
    output logic [3:0] ymsdigit,
    output logic [3:0] ymiddigit,
    output logic [3:0] ylsdigit,
    output logic       busy
);
    localparam logic [1:0] S_IDLE = 2'd0, S_CONV = 2'd1, S_PUB = 2'd2, S_HOLD = 2'd3;
    localparam logic [HW-1:0] HOLD_C = HW'(HOLD);
    logic [1:0] state, c_ovf, c_sign, p_ovf, p_sign, ld_ovf, ld_sign;
    logic [7:0] p_x, p_y, ld_x, ld_y;
    logic [20:0] xs, ys;
    logic [3:0] cnt;
    logic [HW-1:0] hcnt;
    logic dav_q, pend, det, end_hold, take_new, take_pend;

    function automatic logic [8:0] mag(input logic s, input logic [7:0] d);
        return s ? 9'd0 - {1'b1, d} : {1'b0, d};
    endfunction

    // one double-dabble step on {bcd[11:0], bin[8:0]}
    function automatic logic [20:0] dd(input logic [20:0] s);
        logic [11:0] b;
        for (int i = 0; i < 3; i++)
            b[4*i+:4] = s[9+4*i+:4] >= 4'd5 ? s[9+4*i+:4] + 4'd3 : s[9+4*i+:4];
        return {b[10:0], s[8:0], 1'b0};
    endfunction

    assign det = dav & ~dav_q;
    assign busy = state != S_IDLE;

    always_comb begin
        end_hold  = (state == S_HOLD && hcnt == HOLD_C) || (state == S_PUB && HOLD == 0);
        take_new  = det && (state == S_IDLE || end_hold);
        take_pend = end_hold && !det && pend;
        ld_ovf    = take_new ? ovf : p_ovf;
        ld_sign   = take_new ? sign : p_sign;
        ld_x      = take_new ? mousexdata : p_x;
        ld_y      = take_new ? mouseydata : p_y;
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state <= S_IDLE;
            dav_q <= 1'b0;
            pend <= 1'b0;
            hcnt <= '0;
            cnt <= '0;
            xs <= '0;
            ys <= '0;
            c_ovf <= '0;
            c_sign <= '0;
            p_ovf <= '0;
            p_sign <= '0;
            p_x <= '0;
            p_y <= '0;
            dataav <= 1'b0;
            xneg <= 1'b0;
            yneg <= 1'b0;
            {xmsdigit, xmiddigit, xlsdigit} <= '0;
            {ymsdigit, ymiddigit, ylsdigit} <= '0;
        end else begin
            dav_q <= dav;
            dataav <= 1'b0;
            if (det && !take_new) begin
                pend <= 1'b1;
                {p_ovf, p_sign, p_x, p_y} <= {ovf, sign, mousexdata, mouseydata};
            end else if (take_new || take_pend) begin
                pend <= 1'b0;
            end
            if (take_new || take_pend) begin
                xs <= {12'd0, mag(ld_sign[0], ld_x)};
                ys <= {12'd0, mag(ld_sign[1], ld_y)};
                c_ovf <= ld_ovf;
                c_sign <= ld_sign;
                cnt <= '0;
                state <= S_CONV;
            end else if (end_hold) begin
                state <= S_IDLE;
            end else if (state == S_CONV) begin
                if (cnt == 4'd9) begin
                    state <= S_PUB;
                    dataav <= 1'b1;
                    xneg <= c_sign[0];
                    yneg <= c_sign[1];
                    {xmsdigit, xmiddigit, xlsdigit} <= c_ovf[0] ? 12'h999 : xs[20:9];
                    {ymsdigit, ymiddigit, ylsdigit} <= c_ovf[1] ? 12'h999 : ys[20:9];
                end else begin
                    xs <= dd(xs);
                    ys <= dd(ys);
                    cnt <= cnt + 4'd1;
                end
            end else if (state == S_PUB) begin
                state <= S_HOLD;
                hcnt <= HW'(1);
            end else if (state == S_HOLD) begin
                hcnt <= hcnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mouse_bcd_conv.sv
// tb_mouse_bcd_conv: scoreboard bench; stimulus pushes expected publishes, a monitor pops them on dataav
module tb_mouse_bcd_conv;
    localparam int HOLD = 20;
    logic CLK = 1'b0, RSTN = 1'b0, dav = 1'b0;
    logic [1:0] sign = '0, ovf = '0;
    logic [7:0] mx = '0, my = '0;
    logic dataav, xneg, yneg, busy;
    logic [3:0] xmsdigit, xmiddigit, xlsdigit, ymsdigit, ymiddigit, ylsdigit;
    logic [25:0] obs, held = '0;
    int n_chk = 0, n_err = 0, cyc = 0, last_pub = 0;

    typedef struct {
        logic [25:0] v;
        int c;
        bit rel;
    } exp_t;
    exp_t q[$];
    exp_t me;

    mouse_bcd_conv #(.HOLD(HOLD), .HW(8)) dut (
        .CLK(CLK), .RSTN(RSTN), .dav(dav), .sign(sign), .ovf(ovf),
        .mousexdata(mx), .mouseydata(my), .dataav(dataav), .xneg(xneg), .yneg(yneg),
        .xmsdigit(xmsdigit), .xmiddigit(xmiddigit), .xlsdigit(xlsdigit),
        .ymsdigit(ymsdigit), .ymiddigit(ymiddigit), .ylsdigit(ylsdigit), .busy(busy)
    );

    assign obs = {xneg, yneg, xmsdigit, xmiddigit, xlsdigit, ymsdigit, ymiddigit, ylsdigit};

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // magnitude of the 9-bit signed value as decimal digits, 999 on overflow
    function automatic logic [11:0] bcd3(input logic s, input logic o, input logic [7:0] d);
        int m;
        m = s ? 256 - int'(d) : int'(d);
        if (o) m = 999;
        return {4'(m / 100), 4'(m / 10 % 10), 4'(m % 10)};
    endfunction

    function automatic logic [25:0] model(input logic [1:0] s, input logic [1:0] o,
                                          input logic [7:0] x, input logic [7:0] y);
        return {s[0], s[1], bcd3(s[0], o[0], x), bcd3(s[1], o[1], y)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic send(input logic [1:0] s, input logic [1:0] o, input logic [7:0] x,
                        input logic [7:0] y, input bit ex_abs, input bit ex_rel);
        @(negedge CLK);
        if (ex_abs) q.push_back('{model(s, o, x, y), cyc + 11, 1'b0});
        if (ex_rel) q.push_back('{model(s, o, x, y), 0, 1'b1});
        sign = s;
        ovf = o;
        mx = x;
        my = y;
        dav = 1'b1;
        @(negedge CLK);
        dav = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy; i++) @(negedge CLK);
        check("idle_timeout", 64'(busy), 64'd0);
        repeat (2) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        if (!RSTN) begin
            held = '0;
        end else if (dataav) begin
            if (q.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL unexpected_dataav at cycle %0d: got dataav=1 expected 0", cyc);
            end else begin
                me = q.pop_front();
                check("digits", 64'(obs), 64'(me.v));
                check("latency", 64'(cyc), 64'(me.rel ? last_pub + HOLD + 11 : me.c));
                held = me.v;
            end
            last_pub = cyc;
        end else begin
            check("hold_stable", 64'(obs), 64'(held));
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        @(negedge CLK);
        check("reset_outputs", 64'({dataav, busy, obs}), 64'd0);
        @(negedge CLK);
        RSTN = 1'b1;
        repeat (2) @(negedge CLK);
        send(2'b00, 2'b00, 8'h05, 8'hC8, 1, 0);
        wait_idle();
        send(2'b11, 2'b00, 8'hFB, 8'h00, 1, 0);
        wait_idle();
        send(2'b00, 2'b01, 8'h12, 8'h63, 1, 0);
        wait_idle();
        for (int k = 0; k < 20; k++) begin
            send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0),
                 8'($urandom), 8'($urandom), 1, 0);
            wait_idle();
        end
        // latest-wins: x=2 is overwritten by x=3 while x=1 is still in flight
        send(2'b00, 2'b00, 8'd1, 8'd0, 1, 0);
        repeat (3) @(negedge CLK);
        send(2'b00, 2'b00, 8'd2, 8'd0, 0, 0);
        repeat (3) @(negedge CLK);
        send(2'b00, 2'b00, 8'd3, 8'd0, 0, 1);
        wait_idle();
        send(2'b11, 2'b00, 8'h77, 8'h88, 0, 0);
        repeat (3) @(negedge CLK);
        #2 RSTN = 1'b0;
        #1 check("midconv_reset", 64'({dataav, busy, obs}), 64'd0);
        repeat (2) @(negedge CLK);
        RSTN = 1'b1;
        repeat (40) @(negedge CLK);
        check("post_reset_idle", 64'(busy), 64'd0);
        @(negedge CLK);
        q.push_back('{model(2'b10, 2'b00, 8'h40, 8'h9C), cyc + 11, 1'b0});
        sign = 2'b10;
        ovf = 2'b00;
        mx = 8'h40;
        my = 8'h9C;
        dav = 1'b1;
        repeat (100) @(negedge CLK);
        dav = 1'b0;
        wait_idle();
        repeat (5) @(negedge CLK);
        check("queue_empty", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/mouse_bcd_conv.md
Name: mouse_bcd_conv

Overview:
- Upstream stage of the LCD text sequencer in the PS/2 mouse test design.
- Consumes PS/2 packet fields from the mouse receiver: dav, sign, ovf, and the X/Y movement bytes.
- Converts signed 9-bit X and Y movement to magnitude, then to three BCD digits each with a sequential double-dabble, and issues a dataav pulse.
- Holds the digits stable for a guaranteed minimum time so the LCD sequencer can write all characters.

Parameters:
- HOLD, 2000000, minimum CLK cycles the published digits stay frozen after each dataav pulse (0 allowed).
- HW, 21, width of the hold counter; must satisfy 2^HW > HOLD.

Ports:
- CLK  in  1  system clock; all logic on its rising edge.
- RSTN  in  1  asynchronous active-low reset.
- dav  in  1  packet-valid from mouse receiver; level, synchronous to CLK; a new packet is signalled by its rising edge.
- sign  in  2  sign[0]=X sign, sign[1]=Y sign (bit 8 of each 9-bit two's-complement value).
- ovf  in  2  ovf[0]=X overflow, ovf[1]=Y overflow.
- mousexdata  in  8  X movement, low 8 bits.
- mouseydata  in  8  Y movement, low 8 bits.
- dataav  out  1  one-cycle pulse: new digits published.
- xneg, yneg  out  1 each  published sign of X / Y.
- xmsdigit, xmiddigit, xlsdigit  out  4 each  X magnitude BCD: hundreds, tens, units.
- ymsdigit, ymiddigit, ylsdigit  out  4 each  Y magnitude BCD: hundreds, tens, units.
- busy  out  1  high in any state other than IDLE.

Behaviour:
Reset (RSTN=0, asynchronous):
- All outputs 0; state IDLE; dav_q=0; pending flag 0; hold counter 0.
- Reset mid-operation aborts immediately and discards any conversion and pending packet.

Edge detect and capture:
- dav_q registers dav; a new packet is detected when dav=1 and dav_q=0.
- On detection, {ovf, sign, mousexdata, mouseydata} are sampled on that same edge.

Magnitude (per axis):
- v = {sign, data} as 9-bit two's complement.
- mag = sign ? (9'd0 - v) : v, giving a range of 0..256; sign=1 with data=0 gives 256.
- If that axis's ovf=1, its digits are forced to 9,9,9 regardless of mag; its neg output still follows sign.

States:
- IDLE:
  - On detection: load X/Y shift registers (9-bit mag, 12-bit BCD cleared); iteration counter = 0; go to CONV.
- CONV, 9 cycles (X and Y in parallel):
  - Each cycle, add 3 to every BCD nibble that is >=5, then shift {bcd, mag} left by one.
  - After the 9th shift, go to PUBLISH.
- PUBLISH, 1 cycle:
  - Output digit and neg registers load on the edge entering PUBLISH.
  - dataav=1 for exactly this cycle.
  - Next state is HOLD, or, if HOLD=0, behave as at the end of HOLD.
- HOLD:
  - Counter runs from 1 to HOLD.
  - At terminal count: if pending=1, clear pending, load the pending packet and go to CONV; otherwise go to IDLE.

Latency and hold:
- Detection on edge t gives dataav high in the cycle after edge t+10; the digits change on that same edge.
- Digits, xneg and yneg change only on entry to PUBLISH; they are otherwise held indefinitely.

Packets arriving while busy (detection during CONV, PUBLISH or HOLD):
- The packet is captured into a single pending slot and pending=1.
- A later packet overwrites the slot (latest wins); earlier ones are dropped silently.
- The conversion in progress is never disturbed.

Detection on the exact cycle HOLD ends: that packet is taken directly, takes priority over the older pending one, and pending is cleared.

A dav level held high produces no further packets until it has been low for at least one cycle.

Test Plan:
- Reset, then dav rise with sign=00, ovf=00, x=8'h05, y=8'hC8 -> dataav pulses 11 cycles after the rising dav sample; X digits 0,0,5; Y digits 2,0,0; xneg=yneg=0.
- sign=01, x=8'hFB; sign=10, y=8'h00 -> X digits 0,0,5 with xneg=1; Y digits 2,5,6 with yneg=1.
- ovf=01, x=8'h12, y=8'h63 -> X digits 9,9,9; Y digits 0,9,9; exactly one dataav pulse.
- HOLD=20; three packets (x=1, x=2, x=3) at 5-cycle spacing -> publish x=1, then exactly one more publish with x=3, starting 20 cycles after the first dataav; digits stable throughout each hold window.
- Assert RSTN=0 during CONV cycle 4 -> all outputs 0 immediately; no dataav after release until a new dav rise.
- dav held high for 100 cycles -> exactly one dataav.
